// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_pkg;

  // Capture FSM: waiting to arm, measuring the high phase, measuring the low phase.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } pwm_cap_state_t;

  localparam int unsigned DefCntW       = 10;
  localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronous active-high reset.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the async input through the flop chain; bit 0 is the metastability catcher.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_valid,
  output logic             o_stalled,
  output logic             o_level
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_pcnt_inc;
  logic             w_timeout;

  logic             r_s_prev;
  pwm_cap_state_t   r_state;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic             r_valid;
  logic             r_stalled;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_pwm_in),
    .o_q  (w_s)
  );

  assign w_rise     = w_s & ~r_s_prev;
  assign w_fall     = ~w_s & r_s_prev;
  assign w_pcnt_inc = r_pcnt + CntOne;
  // Fires on the cycle the period counter would step onto its saturation value.
  assign w_timeout  = (r_pcnt != CntMax) && (w_pcnt_inc == CntMax);

  // Edge-detect delay, capture FSM, saturating counters and registered results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_prev     <= 1'b0;
      r_state      <= StIdle;
      r_pcnt       <= '0;
      r_hcnt       <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_stalled    <= 1'b0;
    end else begin
      r_s_prev <= w_s;
      r_valid  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A rise only arms; the period it starts is not yet complete.
          if (w_rise) begin
            r_state <= StHigh;
            r_pcnt  <= CntOne;
            r_hcnt  <= CntOne;
          end else if (r_pcnt != CntMax) begin
            r_pcnt <= w_pcnt_inc;
            if (w_timeout) begin
              r_stalled <= 1'b1;
            end
          end
        end
        StHigh: begin
          if (w_timeout) begin
            r_state   <= StIdle;
            r_pcnt    <= CntMax;
            r_stalled <= 1'b1;
          end else begin
            r_pcnt <= w_pcnt_inc;
            // High count freezes on the fall cycle itself.
            if (w_fall) begin
              r_state <= StLow;
            end else begin
              r_hcnt <= r_hcnt + CntOne;
            end
          end
        end
        StLow: begin
          // A rise reloads the counter, so it beats a coincident timeout.
          if (w_rise) begin
            r_period_cnt <= r_pcnt;
            r_high_cnt   <= r_hcnt;
            r_valid      <= 1'b1;
            r_stalled    <= 1'b0;
            r_pcnt       <= CntOne;
            r_hcnt       <= CntOne;
            r_state      <= StHigh;
          end else if (w_timeout) begin
            r_state   <= StIdle;
            r_pcnt    <= CntMax;
            r_stalled <= 1'b1;
          end else begin
            r_pcnt <= w_pcnt_inc;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_high_cnt   = r_high_cnt;
  assign o_period_cnt = r_period_cnt;
  assign o_valid      = r_valid;
  assign o_stalled    = r_stalled;
  // Last synchronizer flop, so this output is already registered.
  assign o_level      = w_s;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in `clk` cycles. It is the receive-side counterpart of the `pwm` generator. Typical uses are decoding servo or fan-tach style inputs and loop-back checking of the generator on the iCE40 board. The input is asynchronous. It is synchronized internally, measured rising-edge to rising-edge, and each completed period is published with a one-cycle `valid` strobe.

## Interface
- `CNT_W`, default 10: measurement counter width. The maximum measurable period is 2^CNT_W−1 cycles. The default covers a `WIDTH`=8 generator (period 256).
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pwm_in`; minimum 2.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `pwm_in`, input, 1: asynchronous PWM input.
- `high_cnt`, output, CNT_W: high-phase length of the last completed period, in cycles.
- `period_cnt`, output, CNT_W: rising-to-rising length of the last completed period, in cycles.
- `valid`, output, 1: one-cycle strobe on the cycle new `high_cnt` and `period_cnt` values appear.
- `stalled`, output, 1: no rising edge seen within 2^CNT_W−1 cycles.
- `level`, output, 1: synchronized input level, meaningful while `stalled`=1.

## Operation
- **Synchronizer:** `s` is the last flop of the chain; `s_prev` is `s` delayed one cycle. Both reset to 0.
  - rise = `s` & ~`s_prev`.
  - fall = ~`s` & `s_prev`.
- **States:** IDLE, HIGH, LOW. Reset enters IDLE.
- **IDLE:**
  - Waits for a rise; a fall is ignored.
  - On rise: go to HIGH, load `pcnt`=1 and `hcnt`=1. Nothing is published, because the period is incomplete.
- **HIGH:**
  - `pcnt`++ and `hcnt`++ every cycle.
  - On fall: go to LOW. `hcnt` freezes; it does not increment on the fall cycle.
- **LOW:**
  - `pcnt`++ every cycle.
  - On rise: publish `period_cnt`←`pcnt` and `high_cnt`←`hcnt`, pulse `valid`, clear `stalled`, reload `pcnt`=1 and `hcnt`=1, go to HIGH.
- **Counter semantics:** a rise at cycle t0 followed by a fall at t0+H and the next rise at t0+P publishes `high_cnt`=H and `period_cnt`=P.
- **Saturation and timeout:**
  - `pcnt` saturates at 2^CNT_W−1 and never wraps.
  - When `pcnt` reaches max in any state: go to IDLE, set `stalled`=1, and hold `high_cnt` and `period_cnt`. No `valid` is generated.
  - `pcnt` stays at max in IDLE until the next rise.
- **Leaving stall:** the first rise after a stall only arms the block (IDLE→HIGH). `stalled` clears on the next `valid`.
- **Simultaneous events:** a rise and a timeout cannot coincide, because a rise reloads `pcnt`. If a rise occurs on the cycle `pcnt` would saturate, the rise wins.
- **Impossible transitions:** rise in HIGH and fall in LOW cannot occur by construction.

## Timing
- **Reset values:**
  - `high_cnt`=0, `period_cnt`=0, `valid`=0, `stalled`=0, `level`=0.
  - State IDLE; counters 0.
- **Latency:** with `SYNC_STAGES`=2, suppose `pwm_in` is first sampled high at clock edge k. Then `s` goes high after edge k+1, the rise is registered at edge k+2, and `valid` is high during the cycle after edge k+2.
  - The same latency applies to the fall: the HIGH→LOW transition happens at edge k+2 relative to the fall sample.
  - Latency grows by 1 per additional sync stage.
- **Input pulse widths:** the minimum resolvable high or low phase is 1 cycle. Pulses narrower than 1 `clk` period may be lost.
- **Outputs:** all outputs are registered; no combinational path from `pwm_in`.
- **Reset mid-measurement:** any partial period is discarded. The first subsequent `valid` requires two rising edges after reset deasserts.

## Structure
- **`pwm_pkg`:** holds the state typedef `pwm_cap_state_t` (IDLE, HIGH, LOW).
- **Sub-module `sync_bit`:** a `SYNC_STAGES`-deep synchronizer with synchronous-reset flops, reusable for other async inputs.
- **`pwm_capture` body:** edge detect, the state machine, and the saturating counters.

## Test plan
- **Generator loop-back at 25% duty:** `pwm` with `WIDTH`=8 and `duty`=64 drives `pwm_in`. Required: the first `valid` comes after the second rise, then every 256 cycles, with `high_cnt`=64, `period_cnt`=256, `stalled`=0.
- **Near-100% duty:** generator with `duty`=255. Required: `high_cnt`=255, `period_cnt`=256 on every `valid`.
- **Constant low input:** generator with `duty`=0. Required: no `valid`; `stalled`=1 and `level`=0 exactly 1023 cycles after reset leaves IDLE counting.
- **Stuck high:** hold `pwm_in`=1 after one rise. Required: `stalled`=1 and `level`=1 after `pcnt` saturates; `high_cnt`/`period_cnt` hold their last values.
- **Recovery and reset:**
  - Restart toggling after a stall. Required: `stalled` clears on the first `valid`, which must come after the second rise.
  - Assert `rst` mid-HIGH. Required: outputs go to 0 on the next edge, and no `valid` comes from the partial period.
- **Minimum pulse:** `pwm_in` high 1 cycle, low 2 cycles, repeating. Required: `high_cnt`=1, `period_cnt`=3, and `valid` every 3 cycles.
